// File: rtl/sp_ram_pkg.sv
// Shared types and constants for the two-master single-port RAM arbiter slice.
package sp_ram_pkg;
  localparam int M_CORE      = 0;
  localparam int M_DBG       = 1;
  localparam int RSP_LATENCY = 1;
  localparam int REQ_AW      = 32;
  localparam int REQ_DW      = 32;

  typedef struct packed {
    logic [REQ_AW-1:0]   addr;
    logic                we;
    logic [REQ_DW/8-1:0] be;
    logic [REQ_DW-1:0]   wdata;
  } ram_req_t;
endpackage

// File: rtl/sp_ram_arbiter_if.sv
// Per-master req/gnt/rvalid bundle; index 0 is the core port, index 1 the debug bridge.
interface sp_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                   m_req;
  logic [1:0]                   m_gnt;
  logic [1:0][31:0]             m_addr;
  logic [1:0]                   m_we;
  logic [1:0][DATA_WIDTH/8-1:0] m_be;
  logic [1:0][DATA_WIDTH-1:0]   m_wdata;
  logic [1:0]                   m_rvalid;
  logic [1:0][DATA_WIDTH-1:0]   m_rdata;

  modport master (
    output m_req, m_addr, m_we, m_be, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport slave (
    input  m_req, m_addr, m_we, m_be, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/sp_ram_rsp_track.sv
// Carries grant valid/owner alongside the RAM read pipeline and raises rvalid for the owner.
// Latency equals LATENCY cycles; no backpressure, the response cannot be stalled.
module sp_ram_rsp_track #(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       gnt_vld,
  input  logic       gnt_own,
  output logic [1:0] rvalid
);
  logic [LATENCY-1:0] rsp_vld_q;
  logic [LATENCY-1:0] rsp_own_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      rsp_vld_q <= '0;
      rsp_own_q <= '0;
    end else begin
      rsp_vld_q[0] <= gnt_vld;
      rsp_own_q[0] <= gnt_own;
      for (int i = 1; i < LATENCY; i++) begin
        rsp_vld_q[i] <= rsp_vld_q[i-1];
        rsp_own_q[i] <= rsp_own_q[i-1];
      end
    end
  end

  // Masked during reset so an in-flight response is dropped, not delivered.
  assign rvalid[0] = !rst_i && rsp_vld_q[LATENCY-1] && !rsp_own_q[LATENCY-1];
  assign rvalid[1] = !rst_i && rsp_vld_q[LATENCY-1] &&  rsp_own_q[LATENCY-1];
endmodule

// File: rtl/sp_ram_arbiter.sv
// Fixed-priority core/debug arbiter for one RAM port; grant is combinational, response 1 cycle later.
// The debug master is forced through after MAX_WAIT consecutive denied cycles.
module sp_ram_arbiter
  import sp_ram_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = REQ_DW,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst_i,
  sp_ram_arbiter_if.slave         bus,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);
  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0] wait_q;
  logic       wait_hit;
  logic       gnt_core;
  logic       gnt_dbg;
  logic [1:0] rvalid;
  ram_req_t   req_core;
  ram_req_t   req_dbg;
  ram_req_t   req_win;
  logic       unused_addr;

  assign wait_hit = (wait_q == WAIT_MAX);
  assign gnt_dbg  = !rst_i && bus.m_req[M_DBG] && (!bus.m_req[M_CORE] || wait_hit);
  assign gnt_core = !rst_i && bus.m_req[M_CORE] && !gnt_dbg;

  assign bus.m_gnt[M_CORE] = gnt_core;
  assign bus.m_gnt[M_DBG]  = gnt_dbg;

  assign req_core = '{addr: bus.m_addr[M_CORE], we: bus.m_we[M_CORE],
                      be: bus.m_be[M_CORE], wdata: bus.m_wdata[M_CORE]};
  assign req_dbg  = '{addr: bus.m_addr[M_DBG], we: bus.m_we[M_DBG],
                      be: bus.m_be[M_DBG], wdata: bus.m_wdata[M_DBG]};

  // Idle cycles leave the core request on the bus; only en/we matter to the RAM then.
  assign req_win     = gnt_dbg ? req_dbg : req_core;
  assign ram_en_o    = gnt_core | gnt_dbg;
  assign ram_we_o    = ram_en_o & req_win.we;
  assign ram_addr_o  = req_win.addr[ADDR_WIDTH-1:0];
  assign ram_be_o    = req_win.be;
  assign ram_wdata_o = req_win.wdata;
  assign unused_addr = ^req_win.addr[REQ_AW-1:ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wait_q <= '0;
    end else if (bus.m_req[M_DBG] && !gnt_dbg) begin
      if (!wait_hit) begin
        wait_q <= wait_q + 4'd1;
      end
    end else begin
      wait_q <= '0;
    end
  end

  sp_ram_rsp_track #(
    .LATENCY (RSP_LATENCY)
  ) u_rsp_track (
    .clk     (clk),
    .rst_i   (rst_i),
    .gnt_vld (ram_en_o),
    .gnt_own (gnt_dbg),
    .rvalid  (rvalid)
  );

  assign bus.m_rvalid         = rvalid;
  assign bus.m_rdata[M_CORE]  = ram_rdata_i;
  assign bus.m_rdata[M_DBG]   = ram_rdata_i;
endmodule
